// File: rtl/aes_iter_ctrl_pkg.sv
// AES-128 iterative controller: shared widths, round count and FSM states.
package aes_iter_ctrl_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES128_ROUNDS = 10;

  typedef logic [AES_BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEY  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/aes_iter_ctrl_if.sv
// Host-side plaintext-in / ciphertext-out valid/ready bundle.
interface aes_iter_ctrl_if;
  import aes_iter_ctrl_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t in_plaintext;
  block_t in_key;
  logic   out_valid;
  logic   out_ready;
  block_t out_ciphertext;

  modport master (
    output in_valid, in_plaintext, in_key, out_ready,
    input  in_ready, out_valid, out_ciphertext
  );

  modport slave (
    input  in_valid, in_plaintext, in_key, out_ready,
    output in_ready, out_valid, out_ciphertext
  );

endinterface

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 controller: one shared round datapath and key
// expander reused for every round, with FSM, state and key registers.
module aes_iter_ctrl
  import aes_iter_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int ROUND_LAT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  aes_iter_ctrl_if.slave  bus,
  output block_t          dp_state,
  output block_t          dp_round_key,
  output logic            dp_final,
  output logic            dp_start,
  input  block_t          dp_result,
  output block_t          kg_key,
  output logic [3:0]      kg_round,
  input  block_t          kg_next_key,
  output logic            busy,
  output logic [3:0]      round_cnt
);

  localparam logic [2:0] LAT  = 3'(ROUND_LAT);
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  state_e     fsm_q, fsm_d;
  block_t     state_reg, state_nxt;
  block_t     key_reg, key_nxt;
  logic [3:0] round_nxt;
  logic [2:0] wait_cnt, wait_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      round_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      fsm_q     <= fsm_d;
      state_reg <= state_nxt;
      key_reg   <= key_nxt;
      round_cnt <= round_nxt;
      wait_cnt  <= wait_nxt;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    state_nxt = state_reg;
    key_nxt   = key_reg;
    round_nxt = round_cnt;
    wait_nxt  = wait_cnt;
    unique case (fsm_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_nxt = bus.in_plaintext ^ bus.in_key;
          key_nxt   = bus.in_key;
          round_nxt = 4'd1;
          fsm_d     = S_KEY;
        end
      end
      S_KEY: begin
        key_nxt  = kg_next_key;
        wait_nxt = LAT;
        fsm_d    = S_WAIT;
      end
      S_WAIT: begin
        wait_nxt = wait_cnt - 3'd1;
        // dp_result is only guaranteed valid in the last WAIT cycle
        if (wait_cnt == 3'd1) begin
          state_nxt = dp_result;
          if (round_cnt == LAST) begin
            fsm_d = S_DONE;
          end else begin
            round_nxt = round_cnt + 4'd1;
            fsm_d     = S_KEY;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          round_nxt = 4'd0;
          fsm_d     = S_IDLE;
        end
      end
    endcase
  end

  assign bus.in_ready       = (fsm_q == S_IDLE) && !rst;
  assign bus.out_valid      = (fsm_q == S_DONE);
  assign bus.out_ciphertext = state_reg;

  assign dp_state     = state_reg;
  assign dp_round_key = key_reg;
  assign dp_final     = (fsm_q == S_WAIT) && (round_cnt == LAST);
  assign dp_start     = (fsm_q == S_WAIT) && (wait_cnt == LAT);

  assign kg_key   = key_reg;
  assign kg_round = round_cnt;
  assign busy     = (fsm_q != S_IDLE);

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Bench for aes_iter_ctrl: two instances (ROUND_LAT 1 and 3) on
// behavioural AES round/key models, checked against a full AES model.
module tb_aes_iter_ctrl;
  import aes_iter_ctrl_pkg::*;

  localparam block_t K1 = 128'h5468617473206d79204b756e67204675;
  localparam block_t P1 = 128'h54776f204f6e65204e696e652054776f;
  localparam block_t C1 = 128'h29c3505f571420f6402299b31a02d73a;
  localparam block_t K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam block_t P2 = 128'h00112233445566778899aabbccddeeff;
  localparam block_t C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam block_t JUNK = 128'hdeadbeef_0badf00d_deadbeef_0badf00d;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // ---------------- AES behavioural model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, base, e, s, t;
    r = 8'h01;
    base = x;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gm(r, base);
      base = gm(base, base);
    end
    s = r;
    t = r;
    for (int i = 0; i < 4; i++) begin
      t = {t[6:0], t[7]};
      s ^= t;
    end
    return s ^ 8'h63;
  endfunction

  function automatic block_t aes_round(input block_t s, input block_t k,
                                       input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] c0, c1, c2, c3;
    block_t o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[r+4*c] = a[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
        b[4*c]   = gm(c0, 8'd2) ^ gm(c1, 8'd3) ^ c2 ^ c3;
        b[4*c+1] = c0 ^ gm(c1, 8'd2) ^ gm(c2, 8'd3) ^ c3;
        b[4*c+2] = c0 ^ c1 ^ gm(c2, 8'd2) ^ gm(c3, 8'd3);
        b[4*c+3] = gm(c0, 8'd3) ^ c1 ^ c2 ^ gm(c3, 8'd2);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  function automatic block_t key_step(input block_t k, input logic [3:0] rnd);
    logic [7:0] rc;
    logic [31:0] w3, t, n0, n1, n2, n3;
    rc = 8'h01;
    for (int j = 1; j < int'(rnd); j++) rc = xt(rc);
    w3 = k[31:0];
    t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    t ^= {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic block_t aes_encrypt(input block_t pt, input block_t key);
    block_t s, k;
    s = pt ^ key;
    k = key;
    for (int r = 1; r <= 10; r++) begin
      k = key_step(k, 4'(r));
      s = aes_round(s, k, r == 10);
    end
    return s;
  endfunction

  // ---------------- stimulus and DUTs ----------------
  logic   s_valid, s_ready;
  block_t s_pt, s_key;

  aes_iter_ctrl_if b1 ();
  aes_iter_ctrl_if b3 ();
  assign b1.in_valid = s_valid;
  assign b1.in_plaintext = s_pt;
  assign b1.in_key = s_key;
  assign b1.out_ready = s_ready;
  assign b3.in_valid = s_valid;
  assign b3.in_plaintext = s_pt;
  assign b3.in_key = s_key;
  assign b3.out_ready = s_ready;

  block_t dps1, dpk1, dpr1, kgk1, kgn1;
  block_t dps3, dpk3, dpr3, kgk3, kgn3;
  logic dpf1, dpst1, busy1, dpf3, dpst3, busy3;
  logic [3:0] kgr1, rc1, kgr3, rc3;

  aes_iter_ctrl #(.NUM_ROUNDS(10), .ROUND_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .dp_state(dps1), .dp_round_key(dpk1), .dp_final(dpf1),
    .dp_start(dpst1), .dp_result(dpr1), .kg_key(kgk1),
    .kg_round(kgr1), .kg_next_key(kgn1), .busy(busy1),
    .round_cnt(rc1)
  );

  aes_iter_ctrl #(.NUM_ROUNDS(10), .ROUND_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3),
    .dp_state(dps3), .dp_round_key(dpk3), .dp_final(dpf3),
    .dp_start(dpst3), .dp_result(dpr3), .kg_key(kgk3),
    .kg_round(kgr3), .kg_next_key(kgn3), .busy(busy3),
    .round_cnt(rc3)
  );

  // round wrappers: result is junk except in the ROUND_LAT-th cycle
  int age1 = 0;
  int age3 = 0;
  always @(posedge clk) begin
    age1 <= dpst1 ? 1 : (age1 < 15 ? age1 + 1 : age1);
    age3 <= dpst3 ? 1 : (age3 < 15 ? age3 + 1 : age3);
  end
  assign dpr1 = ((dpst1 ? 0 : age1) == 0) ? aes_round(dps1, dpk1, dpf1) : JUNK;
  assign dpr3 = ((dpst3 ? 0 : age3) == 2) ? aes_round(dps3, dpk3, dpf3) : JUNK;
  assign kgn1 = key_step(kgk1, kgr1);
  assign kgn3 = key_step(kgk3, kgr3);

  // observation mux: sel=0 -> ROUND_LAT 1, sel=1 -> ROUND_LAT 3
  logic sel = 1'b0;
  logic o_valid, o_ready, o_busy, o_start, o_final;
  logic [3:0] o_rc, o_kgr;
  block_t o_ct;
  assign o_valid = sel ? b3.out_valid : b1.out_valid;
  assign o_ready = sel ? b3.in_ready : b1.in_ready;
  assign o_ct    = sel ? b3.out_ciphertext : b1.out_ciphertext;
  assign o_busy  = sel ? busy3 : busy1;
  assign o_start = sel ? dpst3 : dpst1;
  assign o_final = sel ? dpf3 : dpf1;
  assign o_rc    = sel ? rc3 : rc1;
  assign o_kgr   = sel ? kgr3 : kgr1;

  // ---------------- collection helpers (no checking) ----------------
  int lat_seen, starts, finals, bad_final, busy_low;
  logic [3:0] rq [$];

  task automatic wait_out();
    lat_seen = -1; starts = 0; finals = 0; bad_final = 0; busy_low = 0;
    rq.delete();
    for (int i = 0; i <= 200; i++) begin
      if (o_start) starts++;
      if (o_final) begin
        finals++;
        if (o_rc != 4'd10) bad_final++;
      end
      if (!o_busy) busy_low++;
      if (o_busy && (rq.size() == 0 || rq[$] != o_kgr)) rq.push_back(o_kgr);
      if (o_valid) begin
        lat_seen = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic offer(input block_t pt, input block_t key);
    s_pt = pt; s_key = key; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic settle();
    int n;
    s_valid = 1'b0; s_ready = 1'b1;
    n = 0;
    while ((busy1 || busy3) && n < 300) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (busy1 || busy3) begin
      nerr++;
      $display("FAIL settle: busy1=%0b busy3=%0b, required both 0", busy1, busy3);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_ready = 1'b1;
    s_pt = '0; s_key = '0; sel = 1'b0;
    @(negedge clk);
    nvec++;
    if (b1.out_valid !== 1'b0 || busy1 !== 1'b0 || rc1 !== 4'd0 ||
        dpst1 !== 1'b0 || b1.in_ready !== 1'b0 || busy3 !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: ov=%b busy=%b rc=%0d st=%b rdy=%b busy3=%b, required 0s",
               b1.out_valid, busy1, rc1, dpst1, b1.in_ready, busy3);
    end
    rst = 1'b0;
    #1;
    nvec++;
    if (b1.in_ready !== 1'b1 || b3.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_release: in_ready=%b/%b, required 1/1",
               b1.in_ready, b3.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_vector1_seq();
    settle();
    sel = 1'b0;
    offer(P1, K1);
    wait_out();
    nvec++;
    if (lat_seen != 20) begin
      nerr++;
      $display("FAIL v1_latency: got %0d, required 20", lat_seen);
    end
    nvec++;
    if (o_ct !== C1) begin
      nerr++;
      $display("FAIL v1_cipher: got %h, required %h", o_ct, C1);
    end
    nvec++;
    if (starts != 10 || finals != 1 || bad_final != 0 || busy_low != 0) begin
      nerr++;
      $display("FAIL seq_counts: starts=%0d finals=%0d badf=%0d busylow=%0d, required 10 1 0 0",
               starts, finals, bad_final, busy_low);
    end
    begin
      bit ok;
      ok = (rq.size() == 10);
      for (int k = 0; k < rq.size() && k < 10; k++)
        if (rq[k] != 4'(k + 1)) ok = 1'b0;
      nvec++;
      if (!ok) begin
        nerr++;
        $display("FAIL seq_kg_round: %0d values, required 1..10 in order", rq.size());
      end
    end
    @(negedge clk);
    nvec++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_ready !== 1'b1 || o_rc !== 4'd0) begin
      nerr++;
      $display("FAIL v1_handshake: busy=%b ov=%b rdy=%b rc=%0d, required 0 0 1 0",
               o_busy, o_valid, o_ready, o_rc);
    end
  endtask

  task automatic test_vector2_lat3();
    settle();
    sel = 1'b1;
    offer(P2, K2);
    wait_out();
    nvec++;
    if (lat_seen != 40) begin
      nerr++;
      $display("FAIL v2_lat3_latency: got %0d, required 40", lat_seen);
    end
    nvec++;
    if (o_ct !== C2) begin
      nerr++;
      $display("FAIL v2_lat3_cipher: got %h, required %h", o_ct, C2);
    end
    nvec++;
    if (starts != 10 || finals != 3 || bad_final != 0) begin
      nerr++;
      $display("FAIL v2_lat3_seq: starts=%0d finals=%0d badf=%0d, required 10 3 0",
               starts, finals, bad_final);
    end
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    settle();
    sel = 1'b0;
    s_ready = 1'b0;
    offer(P1, K1);
    wait_out();
    nvec++;
    if (lat_seen != 20 || o_ct !== C1) begin
      nerr++;
      $display("FAIL bp_first: lat=%0d ct=%h, required 20 %h", lat_seen, o_ct, C1);
    end
    s_pt = P2; s_key = K2; s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nvec++;
      if (o_valid !== 1'b1 || o_ct !== C1 || o_ready !== 1'b0 || o_rc !== 4'd10) begin
        nerr++;
        $display("FAIL bp_hold%0d: ov=%b ct=%h rdy=%b rc=%0d, required 1 %h 0 10",
                 k, o_valid, o_ct, o_ready, o_rc, C1);
      end
    end
    s_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      nerr++;
      $display("FAIL bp_release: ov=%b rdy=%b busy=%b, required 0 1 0",
               o_valid, o_ready, o_busy);
    end
    @(negedge clk);
    s_valid = 1'b0;
    nvec++;
    if (o_busy !== 1'b1 || o_rc !== 4'd1) begin
      nerr++;
      $display("FAIL bp_accept: busy=%b rc=%0d, required 1 1", o_busy, o_rc);
    end
    wait_out();
    nvec++;
    if (lat_seen != 20 || o_ct !== C2) begin
      nerr++;
      $display("FAIL bp_second: lat=%0d ct=%h, required 20 %h", lat_seen, o_ct, C2);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    settle();
    sel = 1'b0;
    offer(P1, K1);
    n = 0;
    while (!(o_rc == 4'd5 && o_start) && n < 60) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (!(o_rc == 4'd5 && o_start)) begin
      nerr++;
      $display("FAIL mid_reach_r5: rc=%0d start=%b, required 5 1", o_rc, o_start);
    end
    rst = 1'b1;
    #1;
    nvec++;
    if (b1.out_valid !== 1'b0 || busy1 !== 1'b0 || rc1 !== 4'd0 ||
        dpst1 !== 1'b0 || dpf1 !== 1'b0 || b1.in_ready !== 1'b0 ||
        b1.out_ciphertext !== '0 || dpk1 !== '0) begin
      nerr++;
      $display("FAIL mid_reset: ov=%b busy=%b rc=%0d st=%b fin=%b rdy=%b ct=%h, required all 0",
               b1.out_valid, busy1, rc1, dpst1, dpf1, b1.in_ready, b1.out_ciphertext);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    nvec++;
    if (b1.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL mid_release: in_ready=%b, required 1", b1.in_ready);
    end
    @(negedge clk);
    offer(P2, K2);
    wait_out();
    nvec++;
    if (lat_seen != 20 || o_ct !== C2) begin
      nerr++;
      $display("FAIL mid_next: lat=%0d ct=%h, required 20 %h", lat_seen, o_ct, C2);
    end
  endtask

  task automatic test_back_to_back();
    settle();
    sel = 1'b0;
    s_ready = 1'b1;
    s_pt = P1; s_key = K1; s_valid = 1'b1;
    @(negedge clk);
    s_pt = P2; s_key = K2;
    wait_out();
    nvec++;
    if (lat_seen != 20 || o_ct !== C1) begin
      nerr++;
      $display("FAIL b2b_first: lat=%0d ct=%h, required 20 %h", lat_seen, o_ct, C1);
    end
    @(negedge clk);
    nvec++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_gap: rdy=%b busy=%b, required 1 0", o_ready, o_busy);
    end
    @(negedge clk);
    s_valid = 1'b0;
    nvec++;
    if (o_busy !== 1'b1 || o_rc !== 4'd1) begin
      nerr++;
      $display("FAIL b2b_accept: busy=%b rc=%0d, required 1 1", o_busy, o_rc);
    end
    wait_out();
    nvec++;
    if (lat_seen != 20 || o_ct !== C2) begin
      nerr++;
      $display("FAIL b2b_second: lat=%0d ct=%h, required 20 %h", lat_seen, o_ct, C2);
    end
  endtask

  task automatic test_random();
    block_t pt, key, exp;
    for (int t = 0; t < 6; t++) begin
      settle();
      sel = 1'($urandom_range(0, 1));
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      exp = aes_encrypt(pt, key);
      offer(pt, key);
      wait_out();
      nvec++;
      if (lat_seen != (sel ? 40 : 20) || o_ct !== exp) begin
        nerr++;
        $display("FAIL rand%0d sel=%0d: lat=%0d ct=%h, required %0d %h",
                 t, sel, lat_seen, o_ct, sel ? 40 : 20, exp);
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vector1_seq();
    test_vector2_lat3();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
